tanh_lut_arbiter: RTL
=====================

# tanh_lut_arbiter

Round-robin arbiter that shares one 14-bit tanh LUT (1 clk read latency, 4.10 signed fixed point in and out) among N_REQ requesters, such as the per-neuron activation stages of the LSTM cell. It accepts one request per cycle through a valid/ready handshake and drives the LUT's valid pulse and address. It tags each issued read with the requester index and routes the returned tanh value back to that requester as a one-cycle response pulse. An enable input pauses new grants while in-flight reads drain.

## Interface

**Parameters**

- `N_REQ`, default 4: number of requesters, 2..16.
- `LUT_LAT`, default 1: LUT read latency in clk cycles, from LUT valid-in to LUT valid-out.
- `SIM_DLY`, default 1: simulation delay applied to register assignments.

**Ports**

- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `i_enable` input 1: when high, grants are allowed.
- `i_req_valid` input N_REQ: per-requester request valid.
- `i_req_x` input N_REQ*14: per-requester operand. Requester k occupies bits [14k+13:14k].
- `o_req_ready` output N_REQ: grant, at most one bit high. The handshake fires when valid and ready are both high in the same cycle.
- `o_rsp_valid` output N_REQ: one-cycle response pulse to the owning requester.
- `o_rsp_tanh_x` output 14: response data, valid only while some `o_rsp_valid` bit is high.
- `o_lut_valid_pls` output 1: drives the LUT `i_valid_pls`.
- `o_lut_x` output 14: drives the LUT `i_x`.
- `i_lut_valid_pls` input 1: from the LUT `o_valid_pls`.
- `i_lut_tanh_x` input 14: from the LUT `o_tanh_x`.
- `o_busy` output 1: high while any read is in flight or any `o_rsp_valid` bit is pending.
- `o_err` output 1: sticky flag for a LUT return with no matching tag.

## Operation

**Arbitration (combinational)**
- Grant only when `i_enable` is high.
- Search from index `rr_ptr` upward, modulo N_REQ. The first requester with `i_req_valid` high receives `o_req_ready`.
- `rr_ptr` resets to 0. After a handshake with requester g, `rr_ptr` becomes (g+1) mod N_REQ. With no handshake, `rr_ptr` holds.
- Throughput is one grant per cycle. A requester holding `i_req_valid` continuously is served every cycle only if no other requester is valid.

**Requester rules**
- `i_req_x` must stay stable while `i_req_valid` is high and not yet granted.
- A requester may drop `i_req_valid` without a grant; the arbiter does not check this.

**Issue (registered)**
- After a handshake in cycle t, `o_lut_valid_pls` is 1 in cycle t+1 and `o_lut_x` equals the granted operand.
- `o_lut_valid_pls` is 0 in any cycle following a cycle without a handshake.
- `o_lut_x` holds its last value when not issuing.

**Tag pipeline**
- A shift register of depth LUT_LAT carries {tag_valid, tag_idx (clog2(N_REQ) bits)}.
- It is loaded from the issue stage and advances every cycle. Its tail aligns with `i_lut_valid_pls`.

**Return (registered)**
- When `i_lut_valid_pls` and the tail tag_valid are both 1: on the next cycle `o_rsp_valid[tail idx]` = 1 and `o_rsp_tanh_x` = `i_lut_tanh_x`.
- When `i_lut_valid_pls` = 1 but the tail tag_valid = 0: set `o_err`, which stays set until reset. The data is dropped.
- When the tail tag_valid = 1 but `i_lut_valid_pls` = 0: set `o_err`. No response is produced.

**Enable**
- `i_enable` falling stops new grants in the same cycle.
- Issued reads complete and responses are still delivered.
- `i_enable` does not affect `o_err` or `rr_ptr`.

**Busy**
- `o_busy` = OR of the issue-stage valid, all tag_valid bits, and the response-stage valid.

**Reset**
- Asynchronous assertion at any time, including mid-flight, clears everything. In-flight tags are discarded and no response is produced for them.
- The LUT shares `rstn`, so no stale return follows.

## Timing

- All outputs reset to 0: `o_req_ready` (rstn low forces 0), `o_rsp_valid`, `o_rsp_tanh_x`, `o_lut_valid_pls`, `o_lut_x`, `o_busy`, `o_err`. `rr_ptr` also resets to 0.
- Handshake in cycle t leads to the LUT issue at t+1, the LUT return at t+1+LUT_LAT, and `o_rsp_valid` at t+2+LUT_LAT. With LUT_LAT=1, the response is at t+3.
- Responses return in grant order, one per cycle at most. Back-to-back grants give back-to-back responses.
- `o_req_ready` is combinational from `i_req_valid`, `i_enable`, and `rr_ptr`. All other outputs are registered.

## Test plan

- **Single request:** requester 2 asserts valid with x=0x0400 (1.0) at cycle 10. Required response:
  - `o_req_ready[2]` = 1 at cycle 10.
  - `o_lut_valid_pls` = 1 with `o_lut_x` = 0x0400 at cycle 11.
  - `o_rsp_valid` = 0b0100 with `o_rsp_tanh_x` = 0x030C (0.7616) at cycle 13.
  - `o_busy` high for cycles 11–13.
- **Full contention:** all 4 requesters hold valid from reset release with x=0x0000, 0x0400, 0x3C00 (-1.0), 0x0800. Required response:
  - Grants go to 0, 1, 2, 3 on consecutive cycles.
  - Responses arrive as 0x0000, 0x030C, 0x3CF4, 0x03DB on consecutive cycles to requesters 0, 1, 2, 3.
- **Pointer fairness:** `rr_ptr` = 3 after a grant to 2, then requesters 0 and 3 both become valid. Required response: grant to 3 first, then to 0.
- **Enable pause:** `i_enable` drops in the cycle after two grants. Required response:
  - No further `o_req_ready`.
  - Both responses are still delivered.
  - `o_busy` falls after the second response.
  - Grants resume the cycle `i_enable` rises.
- **Spurious return:** force `i_lut_valid_pls` = 1 with no outstanding issue. Required response: `o_err` = 1 and stays set; no `o_rsp_valid`.
- **Reset mid-flight:** assert `rstn` low one cycle after a grant. Required response: all outputs are 0 immediately, no response is emitted after release, and the first grant after release follows priority from requester 0.

Source files
------------

// File: rtl/tanh_lut_arbiter.sv
// Round-robin arbiter sharing one tanh LUT among N_REQ requesters.
// Reads are tagged with the requester index, and each result is routed back as a one-cycle pulse.
module tanh_lut_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LUT_LAT = 1,
    parameter int SIM_DLY = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_enable,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [N_REQ*14-1:0]  i_req_x,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [13:0]          o_rsp_tanh_x,
    output logic                 o_lut_valid_pls,
    output logic [13:0]          o_lut_x,
    input  logic                 i_lut_valid_pls,
    input  logic [13:0]          i_lut_tanh_x,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    // Register timing is zero-delay here; the parameter only keeps the interface intact.
    if (SIM_DLY < 0) begin : g_sim_dly_invalid
    end

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic          gnt_found;
    logic          hs;
    logic [13:0]   gnt_x;
    int            k;

    logic          iss_vld;
    logic [IW-1:0] iss_idx;
    logic          tag_vld [LUT_LAT];
    logic [IW-1:0] tag_idx [LUT_LAT];
    logic          tail_vld;
    logic [IW-1:0] tail_idx;
    logic          lut_ok;
    logic          tags_busy;

    // Search upward from rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        k         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(rr_ptr) + i) % N_REQ;
            if (!gnt_found && i_req_valid[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = k[IW-1:0];
            end
        end
    end

    assign hs          = rstn & i_enable & gnt_found;
    assign o_req_ready = hs ? (ONE_HOT0 << gnt_idx) : '0;
    assign gnt_x       = i_req_x[gnt_idx*14 +: 14];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr  <= '0;
            iss_vld <= 1'b0;
            iss_idx <= '0;
            o_lut_x <= '0;
        end else begin
            iss_vld <= hs;
            if (hs) begin
                iss_idx <= gnt_idx;
                o_lut_x <= gnt_x;
                rr_ptr  <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign o_lut_valid_pls = iss_vld;

    // Tag pipeline: stage LUT_LAT-1 lines up with the LUT's valid-out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < LUT_LAT; s++) begin
                tag_vld[s] <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            tag_vld[0] <= iss_vld;
            tag_idx[0] <= iss_idx;
            for (int s = 1; s < LUT_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    assign tail_vld = tag_vld[LUT_LAT-1];
    assign tail_idx = tag_idx[LUT_LAT-1];
    assign lut_ok   = i_lut_valid_pls & tail_vld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_rsp_valid  <= '0;
            o_rsp_tanh_x <= '0;
            o_err        <= 1'b0;
        end else begin
            o_rsp_valid <= lut_ok ? (ONE_HOT0 << tail_idx) : '0;
            if (lut_ok) begin
                o_rsp_tanh_x <= i_lut_tanh_x;
            end
            // A return without a tag, or a tag without a return, is sticky.
            o_err <= o_err | (i_lut_valid_pls ^ tail_vld);
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int s = 0; s < LUT_LAT; s++) begin
            tags_busy = tags_busy | tag_vld[s];
        end
    end

    assign o_busy = iss_vld | tags_busy | (|o_rsp_valid);

endmodule
